// File: rtl/mixer_pkg.sv
// Shared types and helpers for the baseband mixer chain:
// mode encodings, carrier ROM contents, round/saturate.
package mixer_pkg;

  typedef enum logic [1:0] {
    MODE_REAL = 2'd0,
    MODE_QUAD = 2'd1,
    MODE_BYP  = 2'd2,
    MODE_BYP3 = 2'd3
  } mode_e;

  // Half-step offset keeps the quarter wave symmetric about pi/4.
  function automatic int lut_val(int k, int cw, int luta);
    real amp;
    real ang;
    amp = (2.0 ** (cw - 1)) - 1.0;
    ang = 3.14159265358979 * (k + 0.5) / (2.0 ** (luta + 1));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

  function automatic longint rnd_sat(longint p, int sh, int ow);
    longint r;
    longint hi;
    longint lo;
    r = p;
    if (sh > 0)
      r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    if (r > hi)
      r = hi;
    else if (r < lo)
      r = lo;
    return r;
  endfunction

endpackage

// File: rtl/nco_lut.sv
// Quarter-wave sine ROM with quadrant folding.
// Registers signed sin/cos for the phase presented.
module nco_lut
  import mixer_pkg::*;
#(
  parameter int CW   = 10,
  parameter int LUTA = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [LUTA+1:0]      phase,
  output logic signed [CW-1:0] sine,
  output logic signed [CW-1:0] cosine
);

  logic signed [CW-1:0] rom [2**LUTA];

  for (genvar k = 0; k < 2**LUTA; k++) begin : g_rom
    assign rom[k] = CW'(lut_val(k, CW, LUTA));
  end

  logic [1:0]           qs;
  logic [1:0]           qc;
  logic [LUTA-1:0]      a;
  logic signed [CW-1:0] ms;
  logic signed [CW-1:0] mc;

  assign qs = phase[LUTA+1:LUTA];
  assign qc = qs + 2'd1;
  assign a  = phase[LUTA-1:0];
  assign ms = qs[0] ? rom[~a] : rom[a];
  assign mc = qc[0] ? rom[~a] : rom[a];

  always_ff @(posedge clk) begin
    if (reset) begin
      sine   <= '0;
      cosine <= '0;
    end else if (en) begin
      sine   <= qs[1] ? -ms : ms;
      cosine <= qc[1] ? -mc : mc;
    end
  end

endmodule

// File: rtl/iq_mixer_nco.sv
// Quadrature mixer with sample-locked NCO, three-stage pipeline:
// S1 sample/phase capture, S2 carrier lookup, S3 round/saturate.
module iq_mixer_nco
  import mixer_pkg::*;
#(
  parameter int DW   = 18,
  parameter int CW   = 10,
  parameter int PW   = 16,
  parameter int LUTA = 6,
  parameter int OW   = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din,
  input  logic [PW-1:0]        fcw,
  input  logic                 fcw_load,
  input  logic                 phase_clr,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  output logic signed [OW-1:0] iout,
  output logic signed [OW-1:0] qout
);

  localparam int AW = LUTA + 2;
  localparam int MW = DW + CW;

  logic                 acc;
  logic [PW-1:0]        phase_acc;
  logic [PW-1:0]        fcw_act;
  logic [PW-1:0]        p_use;
  logic                 v1, v2, v3;
  logic signed [DW-1:0] din1, din2;
  mode_e                mode1, mode2;
  logic [AW-1:0]        ph1;
  logic signed [CW-1:0] sine, cosine;
  logic signed [MW-1:0] prod_i, prod_q;
  logic signed [OW-1:0] i_nx, q_nx;

  assign acc   = en & in_valid;
  assign p_use = phase_clr ? '0 : phase_acc;

  // A coincident fcw_load only affects the increment after this one.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_acc <= '0;
      fcw_act   <= '0;
    end else if (en) begin
      phase_acc <= acc ? p_use + fcw_act : p_use;
      if (fcw_load)
        fcw_act <= fcw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      din1  <= '0;
      mode1 <= MODE_REAL;
      ph1   <= '0;
    end else if (en) begin
      v1 <= acc;
      if (acc) begin
        din1  <= din;
        mode1 <= mode_e'(mode);
        ph1   <= p_use[PW-1 -: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      din2  <= '0;
      mode2 <= MODE_REAL;
    end else if (en) begin
      v2    <= v1;
      din2  <= din1;
      mode2 <= mode1;
    end
  end

  nco_lut #(
    .CW   (CW),
    .LUTA (LUTA)
  ) u_lut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .phase  (ph1),
    .sine   (sine),
    .cosine (cosine)
  );

  assign prod_i = MW'(din2) * MW'(cosine);
  assign prod_q = MW'(din2) * MW'(sine);

  always_comb begin
    i_nx = '0;
    q_nx = '0;
    case (mode2)
      MODE_REAL: begin
        i_nx = OW'(rnd_sat(longint'(prod_i), CW - 1, OW));
      end
      MODE_QUAD: begin
        i_nx = OW'(rnd_sat(longint'(prod_i), CW - 1, OW));
        q_nx = OW'(rnd_sat(-longint'(prod_q), CW - 1, OW));
      end
      default: begin
        i_nx = OW'(rnd_sat(longint'(din2), 0, OW));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v3   <= 1'b0;
      iout <= '0;
      qout <= '0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        iout <= i_nx;
        qout <= q_nx;
      end
    end
  end

  assign out_valid = v3 & en;

endmodule

// File: tb/tb_iq_mixer_nco.sv
// Directed bench for iq_mixer_nco: an 18-bit and a 16-bit output
// instance share stimulus; outputs are logged and checked in order.
module tb_iq_mixer_nco;

  logic clk = 1'b0;
  logic reset, en, in_valid, fcw_load, phase_clr;
  logic signed [17:0] din;
  logic [15:0] fcw;
  logic [1:0] mode;
  logic ov, sov;
  logic signed [17:0] iout, qout;
  logic signed [15:0] siout, sqout;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [31:0] mi[$], mq[$], si[$], sq[$];

  iq_mixer_nco #(.OW(18)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .din(din), .fcw(fcw), .fcw_load(fcw_load),
    .phase_clr(phase_clr), .mode(mode),
    .out_valid(ov), .iout(iout), .qout(qout)
  );

  iq_mixer_nco #(.OW(16)) dut_s (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .din(din), .fcw(fcw), .fcw_load(fcw_load),
    .phase_clr(phase_clr), .mode(mode),
    .out_valid(sov), .iout(siout), .qout(sqout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ov) begin
      mi.push_back(32'(iout));
      mq.push_back(32'(qout));
    end
    if (sov) begin
      si.push_back(32'(siout));
      sq.push_back(32'(sqout));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input int idx,
                       input int ei, input int eq);
    chk($sformatf("%s_i%0d", tag, idx),
        idx < mi.size() ? mi[idx] : 32'hxxxxxxxx, ei);
    chk($sformatf("%s_q%0d", tag, idx),
        idx < mq.size() ? mq[idx] : 32'hxxxxxxxx, eq);
  endtask

  task automatic chk_s(input string tag, input int idx,
                       input int ei, input int eq);
    chk($sformatf("%s_i%0d", tag, idx),
        idx < si.size() ? si[idx] : 32'hxxxxxxxx, ei);
    chk($sformatf("%s_q%0d", tag, idx),
        idx < sq.size() ? sq[idx] : 32'hxxxxxxxx, eq);
  endtask

  task automatic clear();
    mi.delete();
    mq.delete();
    si.delete();
    sq.delete();
  endtask

  task automatic send(input int n, input int d, input logic [1:0] m);
    in_valid = 1'b1;
    din = 18'(d);
    mode = m;
    repeat (n) tick();
    in_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic load(input logic [15:0] f);
    fcw = f;
    fcw_load = 1'b1;
    tick();
    fcw_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; din = '0;
    fcw = '0; fcw_load = 1'b0; phase_clr = 1'b0; mode = 2'd1;
    repeat (2) tick();
    chk("rst_ov", 32'(ov), 0);
    chk("rst_i", 32'(iout), 0);
    chk("rst_q", 32'(qout), 0);
    reset = 1'b0;

    // fcw 0x4000: latency and first four quadrants
    load(16'h4000);
    clear();
    in_valid = 1'b1; din = 18'sd1000; mode = 2'd1;
    tick(); chk("lat1_ov", 32'(ov), 0);
    tick(); chk("lat2_ov", 32'(ov), 0);
    tick(); chk("lat3_ov", 32'(ov), 1);
    chk("p0_i", 32'(iout), 998);
    chk("p0_q", 32'(qout), -12);
    tick(); in_valid = 1'b0;
    chk("p1_i", 32'(iout), -12);
    chk("p1_q", 32'(qout), -998);
    tick();
    chk("p2_i", 32'(iout), -998);
    chk("p2_q", 32'(qout), 12);
    tick();
    chk("p3_i", 32'(iout), 12);
    chk("p3_q", 32'(qout), 998);
    tick();
    chk("drain_ov", 32'(ov), 0);
    chk("hold_i", 32'(iout), 12);
    repeat (2) tick();

    // fcw 0xC000: phase walks backwards and wraps
    load(16'hC000);
    clear();
    send(6, 1000, 2'd1);
    chk("wrap_n", mi.size(), 6);
    chk_m("wrap", 0, 998, -12);
    chk_m("wrap", 1, 12, 998);
    chk_m("wrap", 2, -998, 12);
    chk_m("wrap", 3, -12, -998);
    chk_m("wrap", 4, 998, -12);
    chk_m("wrap", 5, 12, 998);

    // phase now 0x8000: saturation on the narrow instance
    clear();
    send(1, -131072, 2'd0);
    send(1, -131072, 2'd2);
    chk("sat_n", si.size(), 2);
    chk_m("sat18", 0, 130816, 0);
    chk_s("sat16", 0, 32767, 0);
    chk_m("byp18", 1, -131072, 0);
    chk_s("byp16", 1, -32768, 0);

    // phase 0 -> 0xC000, then clear+load on the same sample
    clear();
    send(1, 1000, 2'd1);
    in_valid = 1'b1; din = 18'sd1000; mode = 2'd1;
    fcw = 16'h4000; fcw_load = 1'b1; phase_clr = 1'b1;
    tick();
    fcw_load = 1'b0; phase_clr = 1'b0;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("clr_n", mi.size(), 5);
    chk_m("clr", 1, 998, -12);
    chk_m("clr", 2, 12, 998);
    chk_m("clr", 3, 998, -12);
    chk_m("clr", 4, -12, -998);

    // enable gap mid-stream, phase starts at 0x8000
    clear();
    in_valid = 1'b1; din = 18'sd1000; mode = 2'd1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        en = 1'b0;
        for (int g = 0; g < 5; g++) begin
          tick();
          chk($sformatf("gap_ov%0d", g), 32'(ov), 0);
        end
        en = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("gap_n", mi.size(), 6);
    chk_m("gap", 0, -998, 12);
    chk_m("gap", 1, 12, 998);
    chk_m("gap", 2, 998, -12);
    chk_m("gap", 3, -12, -998);
    chk_m("gap", 4, -998, 12);
    chk_m("gap", 5, 12, 998);

    // reset with two samples in flight
    clear();
    in_valid = 1'b1; din = 18'sd1000; mode = 2'd1;
    repeat (2) tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_ov", 32'(ov), 0);
    chk("mrst_i", 32'(iout), 0);
    chk("mrst_q", 32'(qout), 0);
    reset = 1'b0;
    send(2, 1000, 2'd1);
    chk("post_n", mi.size(), 2);
    chk_m("post", 0, 998, -12);
    chk_m("post", 1, 998, -12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
